// File: rtl/vga_sync_decoder.sv
// VGA sync receiver: rebuilds pixel column/row from active-low syncs,
// checks sync spacing against the expected raster and reports lock.
module vga_sync_decoder #(
   parameter int HTOTAL   = 800,
   parameter int VTOTAL   = 525,
   parameter int COLS     = 640,
   parameter int ROWS     = 480,
   parameter int HS_START = 656,
   parameter int VS_START = 490
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_ce,
   input  logic       vga_hs_l,
   input  logic       vga_vs_l,
   output logic [9:0] vga_col,
   output logic [8:0] vga_row,
   output logic       vga_display,
   output logic       locked,
   output logic       frame_start,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_ALIGN  = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   localparam logic [9:0]  LP_H_LAST  = 10'(HTOTAL - 1);
   localparam logic [9:0]  LP_V_LAST  = 10'(VTOTAL - 1);
   localparam logic [9:0]  LP_COLS    = 10'(COLS);
   localparam logic [9:0]  LP_ROWS    = 10'(ROWS);
   localparam logic [9:0]  LP_HS      = 10'(HS_START);
   localparam logic [9:0]  LP_VS      = 10'(VS_START);
   localparam logic [10:0] LP_TO_LAST = 11'(2 * HTOTAL - 1);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t      r_state;
   state_t      w_state_n;
   logic        r_hs_q;
   logic        r_vs_q;
   logic [9:0]  r_col;
   logic [9:0]  r_row;
   logic [10:0] r_to_cnt;
   logic        r_frame_err;
   logic        r_locked;
   logic        r_display;
   logic        r_frame_start;
   logic [7:0]  r_err_cnt;

   logic        w_hs_fall;
   logic        w_vs_fall;
   logic        w_col_wrap;
   logic [9:0]  w_col_n;
   logic [9:0]  w_row_n;
   logic        w_h_bad;
   logic        w_v_bad;
   logic [9:0]  w_col_d;
   logic [9:0]  w_row_d;
   logic        w_hs_d;
   logic        w_vs_d;
   logic        w_timeout;
   logic [10:0] w_to_cnt_d;
   logic        w_frame_err_d;
   logic        w_err_inc;
   logic        w_locked_n;

   // Edge detection, raster prediction and realignment datapath
   always_comb begin
      w_hs_fall  = pix_ce & r_hs_q & ~vga_hs_l;
      w_vs_fall  = pix_ce & r_vs_q & ~vga_vs_l;
      w_hs_d     = pix_ce ? vga_hs_l : r_hs_q;
      w_vs_d     = pix_ce ? vga_vs_l : r_vs_q;
      w_col_wrap = (r_col == LP_H_LAST);
      w_col_n    = w_col_wrap ? 10'd0 : r_col + 10'd1;
      if (w_col_wrap) begin
         w_row_n = (r_row == LP_V_LAST) ? 10'd0 : r_row + 10'd1;
      end else begin
         w_row_n = r_row;
      end
      w_h_bad = w_hs_fall & (w_col_n != LP_HS);
      w_v_bad = w_vs_fall & (w_row_n != LP_VS);

      if (!pix_ce) begin
         w_col_d = r_col;
         w_row_d = r_row;
      end else begin
         w_col_d = w_hs_fall ? LP_HS : w_col_n;
         w_row_d = w_vs_fall ? LP_VS : w_row_n;
      end

      // A missing hsync for two whole lines means the source is gone
      w_timeout = pix_ce & ~w_hs_fall & (r_to_cnt == LP_TO_LAST);
      if (!pix_ce) begin
         w_to_cnt_d = r_to_cnt;
      end else if (w_hs_fall || w_timeout) begin
         w_to_cnt_d = 11'd0;
      end else begin
         w_to_cnt_d = r_to_cnt + 11'd1;
      end

      // The ALIGN check reads the old flag; the clear takes effect afterwards
      if (w_vs_fall) begin
         w_frame_err_d = 1'b0;
      end else if (w_h_bad) begin
         w_frame_err_d = 1'b1;
      end else begin
         w_frame_err_d = r_frame_err;
      end
   end

   // Lock state machine: next state and loss-of-lock event
   always_comb begin
      w_state_n = r_state;
      w_err_inc = 1'b0;
      case (r_state)
         S_SEARCH: begin
            if (w_vs_fall) begin
               w_state_n = S_ALIGN;
            end else begin
               w_state_n = S_SEARCH;
            end
         end
         S_ALIGN: begin
            if (w_timeout) begin
               w_state_n = S_SEARCH;
            end else if (w_vs_fall && !w_v_bad && !r_frame_err && !w_h_bad) begin
               w_state_n = S_LOCKED;
            end else begin
               w_state_n = S_ALIGN;
            end
         end
         S_LOCKED: begin
            if (w_h_bad || w_v_bad || w_timeout) begin
               w_state_n = S_SEARCH;
               w_err_inc = 1'b1;
            end else begin
               w_state_n = S_LOCKED;
            end
         end
         default: begin
            w_state_n = S_SEARCH;
         end
      endcase
      w_locked_n = (w_state_n == S_LOCKED);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_SEARCH;
         r_hs_q        <= 1'b0;
         r_vs_q        <= 1'b0;
         r_col         <= 10'd0;
         r_row         <= 10'd0;
         r_to_cnt      <= 11'd0;
         r_frame_err   <= 1'b0;
         r_locked      <= 1'b0;
         r_display     <= 1'b0;
         r_frame_start <= 1'b0;
         r_err_cnt     <= 8'd0;
      end else begin
         r_state       <= w_state_n;
         r_hs_q        <= w_hs_d;
         r_vs_q        <= w_vs_d;
         r_col         <= w_col_d;
         r_row         <= w_row_d;
         r_to_cnt      <= w_to_cnt_d;
         r_frame_err   <= w_frame_err_d;
         r_locked      <= w_locked_n;
         r_display     <= w_locked_n & (w_col_d < LP_COLS) & (w_row_d < LP_ROWS);
         r_frame_start <= pix_ce & w_locked_n & (w_col_d == 10'd0) & (w_row_d == 10'd0);
         r_err_cnt     <= w_err_inc ? sat_inc8(r_err_cnt) : r_err_cnt;
      end
   end

   assign vga_col     = r_col;
   assign vga_row     = r_row[8:0];
   assign vga_display = r_display;
   assign locked      = r_locked;
   assign frame_start = r_frame_start;
   assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder on a miniature 8x6 raster so
// that lock, loss and saturation scenarios finish quickly.
module tb_vga_sync_decoder;

   localparam int H  = 8;
   localparam int V  = 6;
   localparam int C  = 5;
   localparam int R  = 4;
   localparam int HS = 6;
   localparam int VS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pix_ce = 1'b0;
   logic       vga_hs_l = 1'b1;
   logic       vga_vs_l = 1'b1;
   logic [9:0] vga_col;
   logic [8:0] vga_row;
   logic       vga_display;
   logic       locked;
   logic       frame_start;
   logic [7:0] err_cnt;

   typedef struct {
      int col;
      int row;
      bit dchk;
      bit disp;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   s_col, s_row, src_vt, g_row;
   bit   hold_hs, g_arm, trk, dchk;
   int   fs_cnt, disp_cnt;

   vga_sync_decoder #(
      .HTOTAL(H), .VTOTAL(V), .COLS(C), .ROWS(R), .HS_START(HS), .VS_START(VS)
   ) dut (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .vga_hs_l(vga_hs_l), .vga_vs_l(vga_vs_l),
      .vga_col(vga_col), .vga_row(vga_row), .vga_display(vga_display),
      .locked(locked), .frame_start(frame_start), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic do_reset(input bit hs, input bit vs);
      rst = 1'b1;
      pix_ce = 1'b0;
      vga_hs_l = hs;
      vga_vs_l = vs;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      s_col = 0; s_row = 0; src_vt = V;
      hold_hs = 1'b0; g_arm = 1'b0; g_row = 0; trk = 1'b0; dchk = 1'b0;
      sbq.delete();
      fs_cnt = 0; disp_cnt = 0;
   endtask

   // One clk of the reference source; with ce the next pixel is presented
   task automatic tick(input bit ce);
      exp_t e;
      int   hs_col;
      pix_ce = ce;
      if (ce) begin
         hs_col = HS + ((g_arm && s_row == g_row) ? 1 : 0);
         vga_hs_l = (hold_hs || s_col != hs_col) ? 1'b1 : 1'b0;
         vga_vs_l = (s_row == VS) ? 1'b0 : 1'b1;
         if (trk) begin
            e.col = s_col; e.row = s_row; e.dchk = dchk;
            e.disp = (s_col < C) && (s_row < R);
            sbq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) fs_cnt++;
      if (ce) begin
         if (vga_display === 1'b1) disp_cnt++;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (vga_col !== 10'(e.col) || vga_row !== 9'(e.row)) begin
               failures++;
               $display("FAIL track: col/row got %0d/%0d expected %0d/%0d",
                        vga_col, vga_row, e.col, e.row);
            end
            if (e.dchk) begin
               checks++;
               if (vga_display !== e.disp) begin
                  failures++;
                  $display("FAIL display: got %b expected %b at col %0d row %0d",
                           vga_display, e.disp, e.col, e.row);
               end
            end
         end
         if (g_arm && s_row == g_row && s_col == H - 1) g_arm = 1'b0;
         if (s_col == H - 1) begin
            s_col = 0;
            s_row = (s_row == src_vt - 1) ? 0 : s_row + 1;
         end else begin
            s_col++;
         end
      end
   endtask

   task automatic raw_px(input bit hs, input bit vs);
      pix_ce = 1'b1;
      vga_hs_l = hs;
      vga_vs_l = vs;
      @(posedge clk);
      #1;
      pix_ce = 1'b0;
   endtask

   task automatic run_until_locked(input int max_px, output int n);
      n = -1;
      for (int i = 0; i < max_px; i++) begin
         tick(1'b1);
         if (locked === 1'b1) begin
            n = i + 1;
            break;
         end
      end
   endtask

   task automatic goto_row1(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (s_row == 1 && s_col == 0) begin
            ok = 1'b1;
            break;
         end
         tick(1'b1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vga_hs_l = 1'b1;
      vga_vs_l = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (vga_col !== 10'd0 || vga_row !== 9'd0 || locked !== 1'b0 ||
          vga_display !== 1'b0 || frame_start !== 1'b0 || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset: col=%0d row=%0d lock=%b disp=%b fs=%b err=%0d, all expected 0",
                  vga_col, vga_row, locked, vga_display, frame_start, err_cnt);
      end
   endtask

   task automatic test_clean_alternating();
      int lock_p;
      do_reset(1'b1, 1'b1);
      lock_p = -1;
      for (int p = 0; p <= 176; p++) begin
         trk  = (p >= 8);
         dchk = (p >= 81);
         if (p == 81) begin
            checks++;
            if (fs_cnt != 0 || disp_cnt != 0) begin
               failures++;
               $display("FAIL prelock_out: fs=%0d disp=%0d expected 0/0", fs_cnt, disp_cnt);
            end
            fs_cnt = 0;
            disp_cnt = 0;
         end
         tick(1'b1);
         if (locked === 1'b1 && lock_p < 0) lock_p = p;
         tick(1'b0);
      end
      checks++;
      if (lock_p != 80) begin
         failures++;
         $display("FAIL lock_time: locked at pixel %0d expected 80", lock_p);
      end
      checks++;
      if (fs_cnt != 2) begin
         failures++;
         $display("FAIL frame_start_cnt: got %0d expected 2", fs_cnt);
      end
      checks++;
      if (disp_cnt != 40) begin
         failures++;
         $display("FAIL display_cnt: got %0d expected 40", disp_cnt);
      end
   endtask

   task automatic test_hs_delay();
      int n;
      bit ok;
      do_reset(1'b1, 1'b1);
      run_until_locked(200, n);
      checks++;
      if (n != 81) begin
         failures++;
         $display("FAIL lock_cont: locked after %0d pixels expected 81", n);
      end
      goto_row1(ok);
      g_arm = 1'b1;
      g_row = 1;
      trk = 1'b1;
      for (int i = 0; i < H - 1; i++) tick(1'b1);
      trk = 1'b0;
      tick(1'b1);
      checks++;
      if (!ok || locked !== 1'b0 || err_cnt !== 8'd1 || vga_col !== 10'd6) begin
         failures++;
         $display("FAIL hs_delay: ok=%b lock=%b err=%0d col=%0d expected 1/0/1/6",
                  ok, locked, err_cnt, vga_col);
      end
      run_until_locked(200, n);
      checks++;
      if (n != 65 || err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL relock: after %0d pixels err=%0d expected 65 and 1", n, err_cnt);
      end
   endtask

   task automatic test_timeout();
      int n, drop_k;
      bit ok;
      do_reset(1'b1, 1'b1);
      run_until_locked(200, n);
      goto_row1(ok);
      hold_hs = 1'b1;
      trk = 1'b1;
      drop_k = -1;
      for (int k = 0; k < 40; k++) begin
         tick(1'b1);
         if (locked !== 1'b1 && drop_k < 0) drop_k = k;
      end
      checks++;
      if (!ok || drop_k != 14) begin
         failures++;
         $display("FAIL timeout_time: ok=%b lock dropped at %0d expected 14", ok, drop_k);
      end
      checks++;
      if (err_cnt !== 8'd1 || locked !== 1'b0) begin
         failures++;
         $display("FAIL timeout_err: err=%0d lock=%b expected 1/0", err_cnt, locked);
      end
   endtask

   task automatic test_vtotal_mismatch();
      bit seen;
      do_reset(1'b1, 1'b1);
      src_vt = V + 1;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick(1'b1);
         if (locked === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL vtotal: ever_locked=%b err=%0d expected 0/0", seen, err_cnt);
      end
   endtask

   task automatic test_low_at_reset();
      do_reset(1'b0, 1'b0);
      repeat (3) raw_px(1'b0, 1'b0);
      checks++;
      if (vga_col !== 10'd3 || vga_row !== 9'd0) begin
         failures++;
         $display("FAIL low_hold: col/row got %0d/%0d expected 3/0", vga_col, vga_row);
      end
      raw_px(1'b1, 1'b0);
      raw_px(1'b0, 1'b0);
      checks++;
      if (vga_col !== 10'd6) begin
         failures++;
         $display("FAIL hs_first_edge: col got %0d expected 6", vga_col);
      end
      raw_px(1'b1, 1'b1);
      raw_px(1'b1, 1'b0);
      checks++;
      if (vga_col !== 10'd0 || vga_row !== 9'd4 || locked !== 1'b0) begin
         failures++;
         $display("FAIL vs_first_edge: col/row/lock got %0d/%0d/%b expected 0/4/0",
                  vga_col, vga_row, locked);
      end
   endtask

   task automatic test_saturation_and_async_reset();
      int  losses, exp_err, n;
      bit  prev;
      do_reset(1'b1, 1'b1);
      losses = 0;
      prev = 1'b0;
      for (int i = 0; i < 40000 && losses < 300; i++) begin
         tick(1'b1);
         if (prev && locked !== 1'b1) begin
            losses++;
            exp_err = (losses > 255) ? 255 : losses;
            checks++;
            if (err_cnt !== 8'(exp_err)) begin
               failures++;
               $display("FAIL err_cnt: got %0d expected %0d after loss %0d", err_cnt, exp_err, losses);
            end
         end
         prev = (locked === 1'b1);
         if (prev && s_row == 5 && s_col == 0 && !g_arm) begin
            g_arm = 1'b1;
            g_row = 5;
         end
      end
      checks++;
      if (losses != 300 || err_cnt !== 8'd255) begin
         failures++;
         $display("FAIL saturate: losses=%0d err=%0d expected 300/255", losses, err_cnt);
      end
      run_until_locked(200, n);
      repeat (3) tick(1'b1);
      checks++;
      if (locked !== 1'b1 || vga_col == 10'd0) begin
         failures++;
         $display("FAIL pre_reset: lock=%b col=%0d expected locked and nonzero col", locked, vga_col);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (vga_col !== 10'd0 || vga_row !== 9'd0 || locked !== 1'b0 ||
          vga_display !== 1'b0 || frame_start !== 1'b0 || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL async_reset: col=%0d row=%0d lock=%b disp=%b fs=%b err=%0d, all expected 0",
                  vga_col, vga_row, locked, vga_display, frame_start, err_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean_alternating();
      test_hs_delay();
      test_timeout();
      test_vtotal_mismatch();
      test_low_at_reset();
      test_saturation_and_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. Samples active-low horizontal/vertical sync on a pixel clock enable and rebuilds the pixel column and row counters. Measures sync spacing against the expected raster, asserts `locked` once a full frame checks out, and counts loss-of-lock events. Used in-system to validate sync from any VGA timing source, and as a self-checking monitor in driver benches.

## Interface
Parameters:
- `HTOTAL`, 800: pixels per line
- `VTOTAL`, 525: lines per frame
- `COLS`, 640: visible columns
- `ROWS`, 480: visible rows
- `HS_START`, 656: column at which `vga_hs_l` first goes low
- `VS_START`, 490: row at which `vga_vs_l` first goes low (at column 0)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `pix_ce`  in  1  pixel enable; all sampling and counting occurs only on `clk` edges with `pix_ce`=1
- `vga_hs_l`  in  1  horizontal sync, active low, synchronous to `clk`
- `vga_vs_l`  in  1  vertical sync, active low, synchronous to `clk`
- `vga_col`  out  10  recovered column
- `vga_row`  out  9  recovered row, low 9 bits of the 10-bit row counter
- `vga_display`  out  1  `locked` && col<`COLS` && row<`ROWS`
- `locked`  out  1  high in LOCKED state
- `frame_start`  out  1  one-`clk` pulse when col and row both become 0 while LOCKED
- `err_cnt`  out  8  loss-of-lock count, saturating at 255

## Operation
- Registered previous samples `hs_q`/`vs_q`, updated on `pix_ce`, reset to 0. Reset to 0 means a source already low at reset release produces no edge.
- hs_fall = `pix_ce` && `hs_q` && !`vga_hs_l`. vs_fall is defined the same way on the vertical sync.
- Predicted next values per `pix_ce`:
  - col_n = (col==HTOTAL-1) ? 0 : col+1
  - row_n advances only when col wraps, with row_n = (row==VTOTAL-1) ? 0 : row+1
  - Row and column counters are 10 bits.
- On hs_fall, col loads `HS_START` instead of col_n. h_bad = (col_n != HS_START).
- On vs_fall, row loads `VS_START` instead of row_n. v_bad = (row_n != VS_START).
- hs_fall and vs_fall in the same cycle each apply their own load, independently.
- Timeout counter (11 bits):
  - Counts `pix_ce` since the last hs_fall and clears on hs_fall.
  - Reaching 2*HTOTAL raises `timeout` and clears the counter.
- Sticky `frame_err` flag:
  - Set by h_bad.
  - Cleared on each vs_fall, after that cycle's check has been evaluated.
- State machine (reset to SEARCH):
  - SEARCH: on vs_fall go to ALIGN and clear `frame_err`.
  - ALIGN:
    - `timeout` goes to SEARCH.
    - On vs_fall, go to LOCKED if !v_bad && !`frame_err` && !h_bad. Otherwise stay in ALIGN.
  - LOCKED: h_bad, v_bad or `timeout` goes to SEARCH and increments `err_cnt`, saturating at 255.
- Counters keep running and re-aligning in every state. Only `locked`, `vga_display` and `frame_start` are gated by state.

## Timing
- Reset values: col=0, row=0, `locked`=0, `vga_display`=0, `frame_start`=0, `err_cnt`=0, state SEARCH.
- Latency: on the `clk` edge where a `pix_ce` sample shows a sync edge, the outputs show the realigned value from the next cycle on. Example: `vga_col`=656 one `clk` after the first low `vga_hs_l` sample.
- All outputs are registered, with no combinational path from the sync inputs.
- Cycles with `pix_ce`=0 hold all state. `frame_start` is high for exactly one `clk` even when `pix_ce` is held high continuously.
- Lock time, with a clean source starting at col 0 / row 0: ALIGN at the first vs_fall (pixel 392000), LOCKED at the second (pixel 812000).
- Reset asserted mid-frame: all outputs clear immediately (asynchronous reset). Re-lock requires two vs_fall events.

## Test plan
- Clean 800x525 source, `pix_ce` alternating 1/0:
  - `locked` rises after the second vs_fall.
  - `vga_col`/`vga_row` match the source every pixel thereafter.
  - `frame_start` appears once per 420000 pixels, and `vga_display` is high for exactly 307200 pixels per frame.
- While locked, delay one hs falling edge by 1 pixel:
  - `locked` drops.
  - `err_cnt`=1 and `vga_col` reloads to 656.
  - Relock occurs after two further clean vs_fall events.
- While locked, hold `vga_hs_l` high:
  - `timeout` after 1600 pixels, `locked`=0, `err_cnt` increments once.
  - Counters keep free-running.
- Source with VTOTAL=526: never reaches LOCKED (stays in ALIGN). `err_cnt` stays 0.
- Hold `vga_hs_l`/`vga_vs_l` low through reset release: no edge is detected until a high→low transition occurs.
- 300 forced lock losses: `err_cnt` saturates at 255. Asserting reset mid-frame clears every output on the same `clk` edge.
